// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, redirect, trap/mret, halt/resume,
// a saved exception PC and misaligned-redirect detection.
module pc_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100,
    parameter int                IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_en,
    input  logic            mret_en,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_step,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc_out,
    output logic            misalign_err,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] STEP_C       = XLEN'(IALIGN);
    localparam logic [XLEN-1:0] ALIGN_MASK_C = XLEN'(IALIGN - 1);

    // IALIGN is a power of two, so the low bits alone decide alignment
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr & ALIGN_MASK_C) != {XLEN{1'b0}};
    endfunction

    state_t          state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [XLEN-1:0] epc_r, epc_nxt_s;
    logic            mis_r, mis_nxt_s;
    logic            valid_r, halted_r;

    assign pc_step      = pc_r + STEP_C;
    assign pc_out       = pc_r;
    assign epc_out      = epc_r;
    assign misalign_err = mis_r;
    assign pc_valid     = valid_r;
    assign halted       = halted_r;

    // Next-state, next-pc and exception bookkeeping
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        epc_nxt_s   = epc_r;
        mis_nxt_s   = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (trap_en) begin
                    epc_nxt_s = pc_r;
                    pc_nxt_s  = TRAP_VECTOR;
                end else if (mret_en) begin
                    pc_nxt_s = epc_r;
                end else if (redirect_en && !stall) begin
                    if (is_misaligned(redirect_target)) begin
                        epc_nxt_s = pc_r;
                        pc_nxt_s  = TRAP_VECTOR;
                        mis_nxt_s = 1'b1;
                    end else begin
                        pc_nxt_s = redirect_target;
                    end
                end else if (stall) begin
                    pc_nxt_s = pc_r;
                end else begin
                    pc_nxt_s = pc_step;
                end
                // halt lands after this edge's pc update
                if (halt_req) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_VECTOR;
            epc_r    <= {XLEN{1'b0}};
            mis_r    <= 1'b0;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            epc_r    <= epc_nxt_s;
            mis_r    <= mis_nxt_s;
            valid_r  <= (state_nxt_s == ST_RUN);
            halted_r <= (state_nxt_s == ST_HALT);
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven bench for pc_unit: each vector's expected outputs go into a
// scoreboard queue when driven and are popped and compared after the edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0, stall = 1'b0, redirect_en = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap_en = 1'b0, mret_en = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic [31:0] pc_out, pc_step, epc_out;
    logic        pc_valid, misalign_err, halted;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100), .IALIGN(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
        .redirect_target(redirect_target), .trap_en(trap_en), .mret_en(mret_en),
        .halt_req(halt_req), .resume(resume), .pc_out(pc_out), .pc_step(pc_step),
        .pc_valid(pc_valid), .epc_out(epc_out), .misalign_err(misalign_err),
        .halted(halted)
    );

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] tgt;
        logic        trap, mret, halt, resume;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] epc;
        logic        mis, hlt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] epc;
        logic        mis, hlt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_no = 0;

    function automatic vec_t mk(input logic r, s, rd, input logic [31:0] t,
                                input logic tr, m, h, rs, input logic [31:0] pc,
                                input logic v, input logic [31:0] epc, input logic mis, hl);
        vec_t x;
        x.rst = r; x.stall = s; x.redir = rd; x.tgt = t; x.trap = tr; x.mret = m;
        x.halt = h; x.resume = rs; x.pc = pc; x.valid = v; x.epc = epc; x.mis = mis; x.hlt = hl;
        return x;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, want);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e, got;
        @(negedge clk);
        rst = v.rst; stall = v.stall; redirect_en = v.redir; redirect_target = v.tgt;
        trap_en = v.trap; mret_en = v.mret; halt_req = v.halt; resume = v.resume;
        e.idx = vec_no; e.pc = v.pc; e.valid = v.valid; e.epc = v.epc; e.mis = v.mis; e.hlt = v.hlt;
        sb.push_back(e);
        vec_no++;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("pc_out",       got.idx, pc_out,                got.pc);
        check("pc_step",      got.idx, pc_step,               got.pc + 32'd4);
        check("pc_valid",     got.idx, {31'd0, pc_valid},     {31'd0, got.valid});
        check("epc_out",      got.idx, epc_out,               got.epc);
        check("misalign_err", got.idx, {31'd0, misalign_err}, {31'd0, got.mis});
        check("halted",       got.idx, {31'd0, halted},       {31'd0, got.hlt});
    endtask

    initial begin
        logic [31:0] want_pc;
        //              rst stl rd  target        tr  mr  hlt res  pc            vld epc           mis hlt
        // reset held two cycles, then boot at RESET_VECTOR
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h4,         1, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h8,         1, 32'h0,         0, 0));
        // redirect, then stall (redirect suppressed), then step
        vecs.push_back(mk(1, 0, 1, 32'h40,        0, 0, 0, 0, 32'h40,        1, 32'h0,         0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 0, 0, 32'h40,        1, 32'h0,         0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h80,        0, 0, 0, 0, 32'h40,        1, 32'h0,         0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 0, 0, 32'h40,        1, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h44,        1, 32'h0,         0, 0));
        // trap, mret, trap+mret together
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 0, 0, 32'h100,       1, 32'h44,        0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h104,       1, 32'h44,        0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 0, 0, 32'h44,        1, 32'h44,        0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 0, 0, 32'h100,       1, 32'h44,        0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h104,       1, 32'h44,        0, 0));
        // misaligned redirect acts as a trap with a one-cycle error pulse
        vecs.push_back(mk(1, 0, 1, 32'h42,        0, 0, 0, 0, 32'h100,       1, 32'h104,       1, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h104,       1, 32'h104,       0, 0));
        // mret beats redirect; trap beats stall
        vecs.push_back(mk(1, 0, 1, 32'h200,       0, 1, 0, 0, 32'h104,       1, 32'h104,       0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h108,       1, 32'h104,       0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 0, 0, 32'h100,       1, 32'h108,       0, 0));
        // wrap at top of address space
        vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h108,       0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h108,       0, 0));
        // halt after this edge's redirect, then frozen despite requests
        vecs.push_back(mk(1, 0, 1, 32'h300,       0, 0, 1, 0, 32'h300,       0, 32'h108,       0, 1));
        vecs.push_back(mk(1, 0, 1, 32'h500,       0, 0, 0, 0, 32'h300,       0, 32'h108,       0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 0, 0, 32'h300,       0, 32'h108,       0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 0, 0, 32'h300,       0, 32'h108,       0, 1));
        vecs.push_back(mk(1, 0, 1, 32'h41,        0, 0, 1, 0, 32'h300,       0, 32'h108,       0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 1, 32'h300,       1, 32'h108,       0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h304,       1, 32'h108,       0, 0));
        // reset while stalled
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 0, 0, 32'h304,       1, 32'h108,       0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         1, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h4,         1, 32'h0,         0, 0));
        // reset while halted; halt_req ignored in BOOT
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 1, 0, 32'h100,       0, 32'h4,         0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 1, 1, 32'h0,         0, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0,         1, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h4,         1, 32'h0,         0, 0));
        // misaligned target while stalled is ignored; back-to-back misalign re-triggers
        vecs.push_back(mk(1, 1, 1, 32'h43,        0, 0, 0, 0, 32'h4,         1, 32'h0,         0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h41,        0, 0, 0, 0, 32'h100,       1, 32'h4,         1, 0));
        vecs.push_back(mk(1, 0, 1, 32'h42,        0, 0, 0, 0, 32'h100,       1, 32'h100,       1, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h104,       1, 32'h100,       0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
        end

        // multi-cycle wrap run: sequential steps modelled as modulo-2^32 adds
        want_pc = 32'hFFFF_FFF0;
        drive(mk(1, 0, 1, want_pc, 0, 0, 0, 0, want_pc, 1, 32'h100, 0, 0));
        for (int k = 0; k < 6; k++) begin
            want_pc = want_pc + 32'd4;
            drive(mk(1, 0, 0, 32'h0, 0, 0, 0, 0, want_pc, 1, 32'h100, 0, 0));
        end

        // multi-cycle long stall holds pc, then one step
        for (int k = 0; k < 5; k++) begin
            drive(mk(1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h8, 1, 32'h100, 0, 0));
        end
        drive(mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 32'hC, 1, 32'h100, 0, 0));

        check("sb_empty", vec_no, sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
